// File: rtl/na_sweep_if.sv
// Bus-initiator and result-stream bundle between the sweep master and its peers.
// Latency: none, wires only.
// Backpressure: bus completes on ack_i; results are held while res_ready_i is low.
interface na_sweep_if;
    logic [15:0] addr_o;
    logic        wen_o;
    logic        ren_o;
    logic [31:0] wdata_o;
    logic        ack_i;
    logic [31:0] rdata_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_index_o;
    logic [61:0] res_i_o;
    logic [61:0] res_q_o;

    modport master (
        output addr_o, wen_o, ren_o, wdata_o,
        input  ack_i, rdata_i,
        output res_valid_o,
        input  res_ready_i,
        output res_index_o, res_i_o, res_q_o
    );

    modport slave (
        input  addr_o, wen_o, ren_o, wdata_o,
        output ack_i, rdata_i,
        input  res_valid_o,
        output res_ready_i,
        input  res_index_o, res_i_o, res_q_o
    );
endinterface

// File: rtl/na_sweep_master.sv
// Frequency sweep master: per point write freq, poll/read four sum words, emit one I/Q result.
// Latency: 2 cycles per bus access with a +1 ack; 1 OUT + 1 NEXT cycle per point.
// Backpressure: holds the result in OUT until res_ready_i; missing ack -> sticky error.
module na_sweep_master #(
    parameter logic [15:0] TRIG_ADDR   = 16'h108,
    parameter logic [15:0] SUM_ADDR    = 16'h140,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] f_start_i,
    input  logic [31:0] f_step_i,
    input  logic [15:0] n_points_i,
    na_sweep_if.master  bus,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR, S_WR_WAIT, S_POLL, S_POLL_WAIT,
        S_RD, S_RD_WAIT, S_OUT, S_NEXT, S_ERR
    } state_t;

    state_t      state;
    logic [31:0] freq;
    logic [31:0] step;
    logic [15:0] npts;
    logic [15:0] index;
    logic [30:0] i_lo;
    logic [30:0] i_hi;
    logic [30:0] q_lo;
    logic [1:0]  rd_sel;
    logic [15:0] tmo_cnt;

    // Cycle 1 after the strobe has tmo_cnt==1, so the last acceptable ack is at ACK_TIMEOUT.
    logic tmo_hit;
    assign tmo_hit = (tmo_cnt == 16'(ACK_TIMEOUT));

    // Sweep sequencer; every bus and status output is registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            bus.addr_o      <= '0;
            bus.wdata_o     <= '0;
            bus.wen_o       <= 1'b0;
            bus.ren_o       <= 1'b0;
            bus.res_valid_o <= 1'b0;
            bus.res_index_o <= '0;
            bus.res_i_o     <= '0;
            bus.res_q_o     <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            freq            <= '0;
            step            <= '0;
            npts            <= '0;
            index           <= '0;
            i_lo            <= '0;
            i_hi            <= '0;
            q_lo            <= '0;
            rd_sel          <= '0;
            tmo_cnt         <= '0;
        end else begin
            // Strobes and done are single-cycle pulses.
            bus.wen_o <= 1'b0;
            bus.ren_o <= 1'b0;
            done_o    <= 1'b0;
            if (abort_i && state != S_IDLE) begin
                // Abandon whatever is in flight; a late ack lands in IDLE and is ignored.
                state           <= S_IDLE;
                bus.res_valid_o <= 1'b0;
                busy_o          <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (start_i) begin
                            err_o <= 1'b0;
                            freq  <= f_start_i;
                            step  <= f_step_i;
                            npts  <= n_points_i;
                            index <= '0;
                            if (n_points_i == 16'd0) begin
                                done_o <= 1'b1;
                                busy_o <= 1'b0;
                                state  <= S_IDLE;
                            end else begin
                                busy_o      <= 1'b1;
                                state       <= S_WR;
                                bus.wen_o   <= 1'b1;
                                bus.addr_o  <= TRIG_ADDR;
                                bus.wdata_o <= f_start_i;
                            end
                        end
                    end
                    S_WR: begin
                        state   <= S_WR_WAIT;
                        tmo_cnt <= 16'd1;
                    end
                    S_POLL: begin
                        state   <= S_POLL_WAIT;
                        tmo_cnt <= 16'd1;
                    end
                    S_RD: begin
                        state   <= S_RD_WAIT;
                        tmo_cnt <= 16'd1;
                    end
                    S_WR_WAIT, S_POLL_WAIT, S_RD_WAIT: begin
                        if (bus.ack_i) begin
                            if (state == S_WR_WAIT) begin
                                state      <= S_POLL;
                                bus.ren_o  <= 1'b1;
                                bus.addr_o <= SUM_ADDR;
                            end else if (state == S_POLL_WAIT) begin
                                // Bit 31 set means the responder is still averaging.
                                bus.ren_o <= 1'b1;
                                if (bus.rdata_i[31]) begin
                                    state <= S_POLL;
                                end else begin
                                    i_lo       <= bus.rdata_i[30:0];
                                    rd_sel     <= 2'd0;
                                    state      <= S_RD;
                                    bus.addr_o <= SUM_ADDR + 16'h4;
                                end
                            end else begin
                                case (rd_sel)
                                    2'd0:    i_hi <= bus.rdata_i[30:0];
                                    2'd1:    q_lo <= bus.rdata_i[30:0];
                                    default: begin
                                        state           <= S_OUT;
                                        bus.res_valid_o <= 1'b1;
                                        bus.res_index_o <= index;
                                        bus.res_i_o     <= {i_hi, i_lo};
                                        bus.res_q_o     <= {bus.rdata_i[30:0], q_lo};
                                    end
                                endcase
                                if (rd_sel != 2'd2) begin
                                    rd_sel     <= rd_sel + 2'd1;
                                    state      <= S_RD;
                                    bus.ren_o  <= 1'b1;
                                    bus.addr_o <= SUM_ADDR + {12'd0, rd_sel + 2'd2, 2'b00};
                                end
                            end
                        end else if (tmo_hit) begin
                            state  <= S_ERR;
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    S_OUT: begin
                        if (bus.res_ready_i) begin
                            bus.res_valid_o <= 1'b0;
                            state           <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        index <= index + 16'd1;
                        freq  <= freq + step;
                        if (index + 16'd1 == npts) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            state       <= S_WR;
                            bus.wen_o   <= 1'b1;
                            bus.addr_o  <= TRIG_ADDR;
                            bus.wdata_o <= freq + step;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_na_sweep_master.sv
// Directed bench for na_sweep_master with a bus responder model and result/strobe logging.
// Latency: responder acks a configurable number of cycles after each strobe.
// Backpressure: res_ready_i driven per scenario.
module tb_na_sweep_master;
    localparam logic [15:0] TRIG = 16'h108;
    localparam logic [15:0] SUM  = 16'h140;
    localparam int          TO   = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] f_start_i = '0;
    logic [31:0] f_step_i = '0;
    logic [15:0] n_points_i = '0;
    logic        busy_o, done_o, err_o;

    na_sweep_if bus();

    na_sweep_master #(.TRIG_ADDR(TRIG), .SUM_ADDR(SUM), .ACK_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .f_start_i(f_start_i), .f_step_i(f_step_i), .n_points_i(n_points_i),
        .bus(bus), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder configuration and state
    int          ack_dly = 1;
    bit          resp_en = 1'b1;
    int          poll_busy = 0;
    int          poll_cnt = 0;
    int          pend = 0;
    logic [31:0] resp;
    logic [31:0] words [4];

    // Logs
    logic [31:0] wr_q[$];
    logic [15:0] wr_addr_q[$];
    logic [15:0] rd_addr_q[$];
    int          stb_cyc[$];
    logic [15:0] res_idx_q[$];
    logic [61:0] res_i_q[$];
    logic [61:0] res_q_q[$];
    int          n_wen = 0, n_ren = 0, n_both = 0, n_done = 0, cyc = 0;

    // Responder and monitor, both on the falling edge.
    always @(negedge clk_i) begin
        cyc++;
        bus.ack_i   = 1'b0;
        bus.rdata_i = 32'h0;
        if (pend > 0) begin
            pend--;
            if (pend == 0 && resp_en) begin
                bus.ack_i   = 1'b1;
                bus.rdata_i = resp;
            end
        end
        if (bus.wen_o || bus.ren_o) begin
            stb_cyc.push_back(cyc);
            if (bus.wen_o && bus.ren_o) n_both++;
            if (bus.wen_o) begin
                n_wen++;
                wr_q.push_back(bus.wdata_o);
                wr_addr_q.push_back(bus.addr_o);
                resp = 32'h0;
            end else begin
                n_ren++;
                rd_addr_q.push_back(bus.addr_o);
                case (bus.addr_o - SUM)
                    16'h0: begin
                        resp = (poll_cnt < poll_busy) ? 32'h8000_0000 : words[0];
                        poll_cnt++;
                    end
                    16'h4:   resp = words[1];
                    16'h8:   resp = words[2];
                    16'hC:   resp = words[3];
                    default: resp = 32'hDEAD_BEEF;
                endcase
            end
            pend = ack_dly;
        end
        if (done_o) n_done++;
        if (bus.res_valid_o && bus.res_ready_i) begin
            res_idx_q.push_back(bus.res_index_o);
            res_i_q.push_back(bus.res_i_o);
            res_q_q.push_back(bus.res_q_o);
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete(); wr_addr_q.delete(); rd_addr_q.delete(); stb_cyc.delete();
        res_idx_q.delete(); res_i_q.delete(); res_q_q.delete();
        n_wen = 0; n_ren = 0; n_both = 0; n_done = 0; poll_cnt = 0;
    endtask

    task automatic start_sweep(input logic [31:0] fs, input logic [31:0] st, input logic [15:0] np);
        f_start_i = fs; f_step_i = st; n_points_i = np;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (n_done > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({bus.addr_o, bus.wdata_o, bus.wen_o, bus.ren_o} !== 50'h0) begin
            $display("FAIL reset_bus: got addr=%h wdata=%h wen=%b ren=%b, want all 0",
                     bus.addr_o, bus.wdata_o, bus.wen_o, bus.ren_o);
            n_fail++;
        end
        n_tests++;
        if ({bus.res_valid_o, bus.res_index_o, bus.res_i_o, bus.res_q_o} !== 141'h0) begin
            $display("FAIL reset_res: got valid=%b idx=%h i=%h q=%h, want all 0",
                     bus.res_valid_o, bus.res_index_o, bus.res_i_o, bus.res_q_o);
            n_fail++;
        end
        n_tests++;
        if ({busy_o, done_o, err_o} !== 3'b000) begin
            $display("FAIL reset_status: got busy/done/err=%b, want 000", {busy_o, done_o, err_o});
            n_fail++;
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        clear_logs();
        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3; words[3] = 32'h4;
        start_sweep(32'd100, 32'd10, 16'd3);
        n_tests++;
        if (busy_o !== 1'b1) begin
            $display("FAIL basic_busy: got %b, want 1", busy_o); n_fail++;
        end
        wait_done(200, ok);
        n_tests++;
        if (!ok) begin
            $display("FAIL basic_done_timeout: got no done_o, want done_o within 200 cycles"); n_fail++;
        end
        tick(); tick();
        n_tests++;
        if (n_done !== 1 || busy_o !== 1'b0) begin
            $display("FAIL basic_done_count: got done=%0d busy=%b, want 1 and 0", n_done, busy_o); n_fail++;
        end
        n_tests++;
        if (wr_q.size() !== 3 || n_both !== 0) begin
            $display("FAIL basic_writes: got %0d writes, %0d dual strobes, want 3 and 0", wr_q.size(), n_both);
            n_fail++;
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (wr_q[k] !== 32'(100 + 10 * k) || wr_addr_q[k] !== TRIG) begin
                    $display("FAIL basic_wr%0d: got %h@%h, want %h@%h", k, wr_q[k], wr_addr_q[k],
                             32'(100 + 10 * k), TRIG);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (res_idx_q.size() !== 3) begin
            $display("FAIL basic_nres: got %0d results, want 3", res_idx_q.size()); n_fail++;
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (res_idx_q[k] !== 16'(k) || res_i_q[k] !== 62'h1_0000_0001 ||
                    res_q_q[k] !== 62'h2_0000_0003) begin
                    $display("FAIL basic_res%0d: got idx=%0d i=%h q=%h, want idx=%0d i=100000001 q=200000003",
                             k, res_idx_q[k], res_i_q[k], res_q_q[k], k);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (stb_cyc.size() < 4 || stb_cyc[1] - stb_cyc[0] !== 2 ||
            stb_cyc[2] - stb_cyc[1] !== 2 || stb_cyc[3] - stb_cyc[2] !== 2) begin
            $display("FAIL basic_throughput: strobe spacing is not 2 cycles (%0d strobes logged)",
                     stb_cyc.size());
            n_fail++;
        end
    endtask

    task automatic test_poll();
        bit ok;
        clear_logs();
        poll_busy = 2;
        words[0] = 32'h0000_0001; words[1] = 32'h7FFF_FFFF; words[2] = 32'h5; words[3] = 32'h0;
        start_sweep(32'd7, 32'd1, 16'd1);
        wait_done(200, ok);
        n_tests++;
        if (!ok) begin
            $display("FAIL poll_done_timeout: got no done_o, want done_o within 200 cycles"); n_fail++;
        end
        n_tests++;
        if (rd_addr_q.size() !== 6 || rd_addr_q[0] !== SUM || rd_addr_q[1] !== SUM ||
            rd_addr_q[2] !== SUM || rd_addr_q[3] !== SUM + 16'h4 ||
            rd_addr_q[4] !== SUM + 16'h8 || rd_addr_q[5] !== SUM + 16'hC) begin
            $display("FAIL poll_seq: got %0d reads, want 140,140,140,144,148,14C", rd_addr_q.size());
            n_fail++;
        end
        n_tests++;
        if (res_i_q.size() !== 1 || res_i_q[0] !== 62'h3FFF_FFFF_8000_0001 || res_q_q[0] !== 62'h5) begin
            $display("FAIL poll_data: got %0d results i=%h q=%h, want 1 result i=3fffffff80000001 q=5",
                     res_i_q.size(), res_i_q[0], res_q_q[0]);
            n_fail++;
        end
        poll_busy = 0;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        int stb0;
        clear_logs();
        words[0] = 32'h0000_0007; words[1] = 32'hFFFF_FFFF; words[2] = 32'h1; words[3] = 32'h4000_0000;
        bus.res_ready_i = 1'b0;
        start_sweep(32'd50, 32'd1, 16'd1);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.res_valid_o) begin ok = 1'b1; break; end
            tick();
        end
        n_tests++;
        if (!ok) begin
            $display("FAIL bp_valid_timeout: got no res_valid_o, want it within 100 cycles"); n_fail++;
        end
        stb0 = n_wen + n_ren;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (bus.res_valid_o !== 1'b1 || bus.res_index_o !== 16'd0 ||
                bus.res_i_o !== 62'h3FFF_FFFF_8000_0007 || bus.res_q_o !== 62'h2000_0000_0000_0001) begin
                $display("FAIL bp_hold%0d: got v=%b idx=%0d i=%h q=%h, want v=1 idx=0 i=3fffffff80000007 q=2000000000000001",
                         k, bus.res_valid_o, bus.res_index_o, bus.res_i_o, bus.res_q_o);
                n_fail++;
            end
        end
        n_tests++;
        if (n_wen + n_ren !== stb0) begin
            $display("FAIL bp_strobes: got %0d strobes while stalled, want 0", n_wen + n_ren - stb0); n_fail++;
        end
        bus.res_ready_i = 1'b1;
        tick();
        n_tests++;
        if (bus.res_valid_o !== 1'b0) begin
            $display("FAIL bp_release: got res_valid_o=%b after ready, want 0", bus.res_valid_o); n_fail++;
        end
        wait_done(20, ok);
        n_tests++;
        if (!ok) begin
            $display("FAIL bp_done: got no done_o after release, want one"); n_fail++;
        end
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        resp_en = 1'b0;
        start_sweep(32'd1, 32'd1, 16'd1);
        n_tests++;
        if (n_wen !== 1) begin
            $display("FAIL to_strobe: got %0d writes at start, want 1", n_wen); n_fail++;
        end
        repeat (TO) tick();
        n_tests++;
        if (err_o !== 1'b0) begin
            $display("FAIL to_early: got err_o=%b at strobe+%0d, want 0", err_o, TO); n_fail++;
        end
        tick();
        n_tests++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL to_err: got err=%b busy=%b at strobe+%0d, want 1 and 0", err_o, busy_o, TO + 1);
            n_fail++;
        end
        repeat (5) tick();
        n_tests++;
        if (err_o !== 1'b1 || res_idx_q.size() !== 0 || n_wen + n_ren !== 1) begin
            $display("FAIL to_sticky: got err=%b results=%0d strobes=%0d, want 1, 0, 1",
                     err_o, res_idx_q.size(), n_wen + n_ren);
            n_fail++;
        end
        resp_en = 1'b1;
        clear_logs();
        start_sweep(32'd2, 32'd1, 16'd1);
        n_tests++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            $display("FAIL to_restart: got err=%b busy=%b after start, want 0 and 1", err_o, busy_o); n_fail++;
        end
        wait_done(200, ok);
        n_tests++;
        if (!ok || res_idx_q.size() !== 1) begin
            $display("FAIL to_recover: got done=%b results=%0d, want done and 1 result", ok, res_idx_q.size());
            n_fail++;
        end
        tick();
    endtask

    task automatic test_zero_points();
        clear_logs();
        start_sweep(32'd5, 32'd5, 16'd0);
        n_tests++;
        if (done_o !== 1'b1) begin
            $display("FAIL zero_done: got done_o=%b the cycle after start, want 1", done_o); n_fail++;
        end
        repeat (10) tick();
        n_tests++;
        if (n_done !== 1 || n_wen + n_ren !== 0 || busy_o !== 1'b0) begin
            $display("FAIL zero_quiet: got done=%0d strobes=%0d busy=%b, want 1, 0, 0",
                     n_done, n_wen + n_ren, busy_o);
            n_fail++;
        end
    endtask

    task automatic test_abort();
        bit ok;
        clear_logs();
        ack_dly = 6;
        start_sweep(32'd9, 32'd1, 16'd2);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (n_ren > 0) begin ok = 1'b1; break; end
            tick();
        end
        n_tests++;
        if (!ok) begin
            $display("FAIL abort_poll_timeout: got no poll strobe, want one within 40 cycles"); n_fail++;
        end
        tick();
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
            $display("FAIL abort_idle: got busy=%b valid=%b after abort, want 0 and 0", busy_o, bus.res_valid_o);
            n_fail++;
        end
        repeat (12) tick();
        n_tests++;
        if (n_wen !== 1 || n_ren !== 1 || n_done !== 0 || res_idx_q.size() !== 0 ||
            busy_o !== 1'b0 || err_o !== 1'b0) begin
            $display("FAIL abort_late_ack: got wen=%0d ren=%0d done=%0d res=%0d busy=%b err=%b, want 1,1,0,0,0,0",
                     n_wen, n_ren, n_done, res_idx_q.size(), busy_o, err_o);
            n_fail++;
        end
        ack_dly = 1;
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        start_sweep(32'hFFFF_FFF0, 32'h20, 16'd2);
        wait_done(200, ok);
        n_tests++;
        if (!ok || wr_q.size() !== 2 || wr_q[0] !== 32'hFFFF_FFF0 || wr_q[1] !== 32'h0000_0010) begin
            $display("FAIL wrap_freq: got done=%b writes=%0d w0=%h w1=%h, want ffff_fff0 then 0000_0010",
                     ok, wr_q.size(), wr_q[0], wr_q[1]);
            n_fail++;
        end
        n_tests++;
        if (res_idx_q.size() !== 2 || res_idx_q[1] !== 16'd1) begin
            $display("FAIL wrap_results: got %0d results last idx=%0d, want 2 and 1",
                     res_idx_q.size(), res_idx_q[1]);
            n_fail++;
        end
        tick();
    endtask

    initial begin
        bus.res_ready_i = 1'b1;
        words[0] = '0; words[1] = '0; words[2] = '0; words[3] = '0;
        test_reset();
        test_basic();
        test_poll();
        test_backpressure();
        test_timeout();
        test_zero_points();
        test_abort();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
